fifo_rd_packer: RTL and testbench
=================================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter: WIDTH, default 8, byte width of FIFO read data; output word width SHALL be 2*WIDTH.
REQ-002 R_CLK  input  1  read-domain clock; all state SHALL update on its rising edge.
REQ-003 R_RST  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 EMPTY  input  1  FIFO empty flag, read-domain synchronous.
REQ-005 RD_DATA  input  WIDTH  FIFO head data, valid whenever EMPTY=0 (first-word fall-through).
REQ-006 R_INC  output  1  FIFO pop request; FIFO advances on the R_CLK edge where R_INC=1.
REQ-007 FLUSH  input  1  emit a held odd byte as a partial word.
REQ-008 OUT_READY  input  1  downstream accepts OUT_DATA this cycle.
REQ-009 OUT_DATA  output  2*WIDTH  packed word, {high byte, low byte}.
REQ-010 OUT_VALID  output  1  OUT_DATA valid; transfer occurs when OUT_VALID=1 and OUT_READY=1.
REQ-011 OUT_PARTIAL  output  1  qualifies OUT_DATA: high byte is padding (zero).
REQ-012 WORD_CNT  output  16  count of completed output transfers.

Function
REQ-013 Internal state: low-byte holder LO (WIDTH bits) with flag LO_VLD; output register OUT_DATA/OUT_PARTIAL with OUT_VALID.
REQ-014 FSM has two states: NO_LO (LO_VLD=0) and HAVE_LO (LO_VLD=1).
REQ-015 OUT_FREE = !OUT_VALID || OUT_READY (combinational).
REQ-016 R_INC SHALL be combinational: !EMPTY && (NO_LO || OUT_FREE); it SHALL never assert while EMPTY=1.
REQ-017 Pop in NO_LO: LO <= RD_DATA; transition to HAVE_LO; output register unchanged.
REQ-018 Pop in HAVE_LO: OUT_DATA <= {RD_DATA, LO}; OUT_PARTIAL <= 0; OUT_VALID <= 1; transition to NO_LO.
REQ-019 Flush: in HAVE_LO with no pop this cycle, FLUSH=1 and OUT_FREE=1 -> OUT_DATA <= {0, LO}; OUT_PARTIAL <= 1; OUT_VALID <= 1; transition to NO_LO.
REQ-020 Pop has priority over FLUSH: if a pop completes a word in the same cycle, FLUSH is ignored for that cycle.
REQ-021 FLUSH in NO_LO, or with OUT_FREE=0, SHALL have no effect and is not remembered.
REQ-022 OUT_VALID SHALL clear on a transfer cycle unless a new word is loaded in the same cycle; OUT_DATA/OUT_PARTIAL SHALL stay stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 Latency: second byte pop edge to OUT_VALID=1 is one R_CLK cycle; steady-state throughput is one word per two cycles.
REQ-024 WORD_CNT SHALL increment by 1 on each transfer cycle and wrap from 16'hFFFF to 16'h0000.
REQ-025 No byte SHALL be dropped or duplicated under any OUT_READY/EMPTY pattern.

Reset
REQ-026 R_RST=0 SHALL immediately force NO_LO, LO=0, OUT_DATA=0, OUT_VALID=0, OUT_PARTIAL=0, WORD_CNT=0; R_INC SHALL then follow REQ-016 with NO_LO.
REQ-027 Reset mid-operation SHALL discard any held byte and any untransferred output word.
REQ-028 Release of R_RST SHALL take effect on the first R_CLK rising edge after deassertion; no output glitches to 1 during reset.

Verification
REQ-029 FIFO holds A3,B4, OUT_READY=1 -> two R_INC pulses; OUT_DATA=16'hB4A3, OUT_PARTIAL=0, one cycle OUT_VALID; WORD_CNT=1.
REQ-030 FIFO holds 1D,A3,3A,2D, OUT_READY=0 -> one word 16'hA31D held stable, LO=3A held, R_INC=0 with FIFO non-empty; OUT_READY=1 -> 16'hA31D then 16'h2D3A; WORD_CNT=2.
REQ-031 FIFO holds 4B only, then EMPTY=1, pulse FLUSH -> OUT_DATA=16'h004B, OUT_PARTIAL=1; WORD_CNT=1.
REQ-032 HAVE_LO with LO=A5, FLUSH=1 in the same cycle as pop of 22 -> OUT_DATA=16'h22A5, OUT_PARTIAL=0; no partial word emitted.
REQ-033 Assert R_RST=0 while LO=3F held and OUT_VALID=1 -> all outputs 0 immediately; after release, FIFO bytes 45,35 -> OUT_DATA=16'h3545.
REQ-034 Bench: random EMPTY/OUT_READY for 1000 bytes -> output stream equals input stream paired in order; WORD_CNT=500.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Pops bytes from a first-word-fall-through FIFO and packs pairs of them
//   into 2*WIDTH-bit words ({second byte, first byte}). A lone held byte can
//   be pushed out as a partial word (high byte zero) with FLUSH. The output
//   side is a single registered valid/ready stage.
// Ports:
//   R_CLK        read-domain clock
//   R_RST        asynchronous active-low reset
//   EMPTY        FIFO empty flag
//   RD_DATA      FIFO head data (valid while EMPTY=0)
//   R_INC        FIFO pop request (combinational)
//   FLUSH        emit a held odd byte as a partial word
//   OUT_READY    downstream ready
//   OUT_DATA     packed word {high byte, low byte}
//   OUT_VALID    OUT_DATA valid
//   OUT_PARTIAL  high byte of OUT_DATA is padding
//   WORD_CNT     number of completed output transfers (wraps)
module fifo_rd_packer #(
  parameter int WIDTH = 8
) (
  input  logic               R_CLK,
  input  logic               R_RST,
  input  logic               EMPTY,
  input  logic [WIDTH-1:0]   RD_DATA,
  output logic               R_INC,
  input  logic               FLUSH,
  input  logic               OUT_READY,
  output logic [2*WIDTH-1:0] OUT_DATA,
  output logic               OUT_VALID,
  output logic               OUT_PARTIAL,
  output logic [15:0]        WORD_CNT
);

  typedef enum logic [0:0] {
    NO_LO   = 1'b0,
    HAVE_LO = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_partial_q, out_partial_d;
  logic [15:0]        word_cnt_q, word_cnt_d;

  logic out_free_s;
  logic pop_s;
  logic xfer_s;
  logic load_s;

  // Output slot can take a new word if it is empty or being drained now.
  assign out_free_s = !out_valid_q || OUT_READY;
  // A pop into NO_LO only fills LO; a pop into HAVE_LO needs the output slot.
  assign pop_s      = !EMPTY && ((state_q == NO_LO) || out_free_s);
  assign xfer_s     = out_valid_q && OUT_READY;

  // Next-state, byte holder and output-register loading.
  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    out_data_d    = out_data_q;
    out_partial_d = out_partial_q;
    load_s        = 1'b0;
    case (state_q)
      NO_LO: begin
        if (pop_s) begin
          lo_d    = RD_DATA;
          state_d = HAVE_LO;
        end else begin
          state_d = NO_LO;
        end
      end
      HAVE_LO: begin
        // A completing pop wins over FLUSH in the same cycle.
        if (pop_s) begin
          out_data_d    = {RD_DATA, lo_q};
          out_partial_d = 1'b0;
          load_s        = 1'b1;
          state_d       = NO_LO;
        end else if (FLUSH && out_free_s) begin
          out_data_d    = {{WIDTH{1'b0}}, lo_q};
          out_partial_d = 1'b1;
          load_s        = 1'b1;
          state_d       = NO_LO;
        end else begin
          state_d = HAVE_LO;
        end
      end
      default: begin
        state_d = NO_LO;
      end
    endcase

    if (load_s) begin
      out_valid_d = 1'b1;
    end else if (xfer_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (xfer_s) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  // State and output registers; reset discards held byte and pending word.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      state_q       <= NO_LO;
      lo_q          <= {WIDTH{1'b0}};
      out_data_q    <= {(2*WIDTH){1'b0}};
      out_valid_q   <= 1'b0;
      out_partial_q <= 1'b0;
      word_cnt_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      lo_q          <= lo_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_partial_q <= out_partial_d;
      word_cnt_q    <= word_cnt_d;
    end
  end

  assign R_INC       = pop_s;
  assign OUT_DATA    = out_data_q;
  assign OUT_VALID   = out_valid_q;
  assign OUT_PARTIAL = out_partial_q;
  assign WORD_CNT    = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: FIFO model feeding the DUT, a reference
// packing model driving an expected-word queue, directed cases and a
// random EMPTY/OUT_READY stream.
module tb_fifo_rd_packer;

  logic        clk;
  logic        rst_n;
  logic        empty;
  logic [7:0]  rd_data;
  logic        r_inc;
  logic        flush;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_partial;
  logic [15:0] word_cnt;

  fifo_rd_packer #(.WIDTH(8)) dut (
    .R_CLK      (clk),
    .R_RST      (rst_n),
    .EMPTY      (empty),
    .RD_DATA    (rd_data),
    .R_INC      (r_inc),
    .FLUSH      (flush),
    .OUT_READY  (out_ready),
    .OUT_DATA   (out_data),
    .OUT_VALID  (out_valid),
    .OUT_PARTIAL(out_partial),
    .WORD_CNT   (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // FIFO contents and reference model state
  logic [7:0]  fifo_q[$];
  logic [16:0] sb_q[$];      // {partial, word}
  logic        m_pend;
  logic [7:0]  m_lo;
  logic        m_valid;
  logic [15:0] m_cnt;
  logic [15:0] last_word;
  logic        last_part;
  logic        rec_stream;
  logic [7:0]  in_stream[$];
  logic [7:0]  out_stream[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    fifo_q.delete();
    sb_q.delete();
    m_pend  = 1'b0;
    m_lo    = 8'h00;
    m_valid = 1'b0;
    m_cnt   = 16'd0;
  endtask

  // Reset mid-cycle and check outputs drop immediately.
  task automatic do_reset();
    @(negedge clk);
    empty     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("rst_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_data", 32'(out_data), 32'd0);
    chk_eq("rst_part", 32'(out_partial), 32'd0);
    chk_eq("rst_cnt", 32'(word_cnt), 32'd0);
    chk_eq("rst_rinc", 32'(r_inc), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus; inputs set on negedge, checks 1ns later.
  task automatic step(input logic rdy, input logic fl, input logic hold_empty);
    logic       exp_inc;
    logic       free;
    logic [7:0] b;
    @(negedge clk);
    out_ready = rdy;
    flush     = fl;
    empty     = hold_empty || (fifo_q.size() == 0);
    rd_data   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    #1;
    free    = !m_valid || rdy;
    exp_inc = !empty && (!m_pend || free);
    chk_eq("r_inc", 32'(r_inc), 32'(exp_inc));
    chk_eq("out_valid", 32'(out_valid), 32'(m_valid));
    chk_eq("word_cnt", 32'(word_cnt), 32'(m_cnt));
    if (m_valid && rdy) begin
      if (sb_q.size() == 0) begin
        chk_eq("sb_underflow", 32'd0, 32'd1);
      end else begin
        chk_eq("out_data", 32'(out_data), 32'(sb_q[0][15:0]));
        chk_eq("out_partial", 32'(out_partial), 32'(sb_q[0][16]));
        void'(sb_q.pop_front());
      end
      last_word = out_data;
      last_part = out_partial;
      if (rec_stream) begin
        out_stream.push_back(out_data[7:0]);
        out_stream.push_back(out_data[15:8]);
      end
      m_cnt   = m_cnt + 16'd1;
      m_valid = 1'b0;
    end
    if (exp_inc) begin
      b = fifo_q.pop_front();
      if (m_pend) begin
        sb_q.push_back({1'b0, b, m_lo});
        m_pend  = 1'b0;
        m_valid = 1'b1;
      end else begin
        m_lo   = b;
        m_pend = 1'b1;
      end
    end else if (m_pend && fl && free) begin
      sb_q.push_back({1'b1, 8'h00, m_lo});
      m_pend  = 1'b0;
      m_valid = 1'b1;
    end
    @(posedge clk);
  endtask

  initial begin
    int cycles;
    int errs;
    rst_n      = 1'b0;
    empty      = 1'b1;
    rd_data    = 8'h00;
    flush      = 1'b0;
    out_ready  = 1'b0;
    rec_stream = 1'b0;
    last_word  = 16'h0000;
    last_part  = 1'b0;
    model_clear();
    #12;
    rst_n = 1'b1;

    // A3,B4 with OUT_READY=1
    do_reset();
    fifo_q.push_back(8'hA3);
    fifo_q.push_back(8'hB4);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    chk_eq("t1_word", 32'(last_word), 32'h0000B4A3);
    chk_eq("t1_part", 32'(last_part), 32'd0);
    chk_eq("t1_cnt", 32'(word_cnt), 32'd1);

    // Backpressure: 1D,A3,3A,2D with OUT_READY=0
    do_reset();
    fifo_q.push_back(8'h1D);
    fifo_q.push_back(8'hA3);
    fifo_q.push_back(8'h3A);
    fifo_q.push_back(8'h2D);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    chk_eq("t2_hold_data", 32'(out_data), 32'h0000A31D);
    chk_eq("t2_hold_valid", 32'(out_valid), 32'd1);
    chk_eq("t2_fifo_left", 32'(fifo_q.size()), 32'd1);
    chk_eq("t2_rinc_blocked", 32'(r_inc), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk_eq("t2_first", 32'(last_word), 32'h0000A31D);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    chk_eq("t2_second", 32'(last_word), 32'h00002D3A);
    chk_eq("t2_cnt", 32'(word_cnt), 32'd2);

    // Flush of a lone byte
    do_reset();
    fifo_q.push_back(8'h4B);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chk_eq("t3_no_early", 32'(out_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chk_eq("t3_word", 32'(last_word), 32'h0000004B);
    chk_eq("t3_part", 32'(last_part), 32'd1);
    chk_eq("t3_cnt", 32'(word_cnt), 32'd1);

    // FLUSH together with the completing pop
    do_reset();
    fifo_q.push_back(8'hA5);
    step(1'b1, 1'b0, 1'b0);
    fifo_q.push_back(8'h22);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    chk_eq("t4_word", 32'(last_word), 32'h000022A5);
    chk_eq("t4_part", 32'(last_part), 32'd0);
    chk_eq("t4_cnt", 32'(word_cnt), 32'd1);

    // Reset while holding a byte and a pending word
    do_reset();
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h3F);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    chk_eq("t5_pre_valid", 32'(out_valid), 32'd1);
    do_reset();
    fifo_q.push_back(8'h45);
    fifo_q.push_back(8'h35);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    chk_eq("t5_word", 32'(last_word), 32'h00003545);
    chk_eq("t5_cnt", 32'(word_cnt), 32'd1);

    // Random EMPTY / OUT_READY, 1000 bytes
    do_reset();
    rec_stream = 1'b1;
    cycles = 0;
    for (int n = 0; n < 1000; ) begin
      if (fifo_q.size() < 4) begin
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        fifo_q.push_back(v);
        in_stream.push_back(v);
        n++;
      end
      step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 1'b0,
           ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
      cycles++;
    end
    while ((fifo_q.size() != 0 || m_pend || m_valid) && cycles < 20000) begin
      step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      cycles++;
    end
    chk_eq("rand_timeout", 32'(cycles < 20000), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk_eq("rand_cnt", 32'(word_cnt), 32'd500);
    chk_eq("rand_len", 32'(out_stream.size()), 32'd1000);
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i >= out_stream.size() || out_stream[i] !== in_stream[i]) errs++;
    end
    chk_eq("rand_stream", 32'(errs), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
